// File: rtl/clock_pkg.sv
// Shared mode encoding and time limits for the clock setting controller and clock counters.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2
  } mode_e;

  localparam logic [4:0] MAX_HOURS   = 5'd23;
  localparam logic [5:0] MAX_MINUTES = 6'd59;

  function automatic logic [4:0] next_hours(input logic [4:0] h);
    return (h == MAX_HOURS) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [5:0] next_minutes(input logic [5:0] m);
    return (m == MAX_MINUTES) ? 6'd0 : m + 6'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus counting debouncer for one raw active-low key.
// level is the debounced pressed state; press pulses for one cycle on each accepted press.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

  logic [1:0]    sync_q;
  logic          stable_n;
  logic [CW-1:0] cnt;

  // Counter runs only while the synchronized input disagrees with the accepted level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q   <= '1;
      stable_n <= 1'b1;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_n};
      press  <= 1'b0;
      if (sync_q[1] == stable_n) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt      <= '0;
        stable_n <= sync_q[1];
        press    <= ~sync_q[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign level = ~stable_n;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: mode key cycles RUN/SET_HR/SET_MIN, inc key edits a shadow time.
// Define CLOCK_SET_AUTO_REPEAT_EN to build auto-repeat for a held inc key.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter int unsigned BLINK_CYC    = 25000000,
  parameter int unsigned REPEAT_CYC   = 12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  output logic       run_en,
  output logic       load,
  output logic [4:0] load_hours,
  output logic [5:0] load_minutes,
  output logic [5:0] load_seconds,
  output logic [5:0] blank_mask,
  output logic [1:0] mode
);

  localparam int unsigned BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

  mode_e         state_q, state_d;
  logic          mode_press, mode_level;
  logic          inc_press, inc_level;
  logic          repeat_tick;
  logic          inc_evt;
  logic [4:0]    hours_q;
  logic [5:0]    minutes_q;
  logic          load_q, run_en_q;
  logic [BW-1:0] blink_cnt;
  logic          blink_q;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode (
    .clk   (clk),
    .reset (reset),
    .btn_n (btn_mode),
    .level (mode_level),
    .press (mode_press)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_inc (
    .clk   (clk),
    .reset (reset),
    .btn_n (btn_inc),
    .level (inc_level),
    .press (inc_press)
  );

`ifdef CLOCK_SET_AUTO_REPEAT_EN
  localparam int unsigned RW = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
  localparam logic [RW-1:0] REPEAT_LAST = RW'(REPEAT_CYC - 1);

  logic          rep_armed;
  logic [RW-1:0] rep_cnt;
  logic          unused_levels;

  assign unused_levels = &{1'b0, mode_level};
  assign repeat_tick   = rep_armed && inc_level && (rep_cnt == REPEAT_LAST);

  // Armed only by an accepted press inside a SET state; any release or mode change disarms.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rep_armed <= 1'b0;
      rep_cnt   <= '0;
    end else if (mode_press || !inc_level || state_q == MODE_RUN) begin
      rep_armed <= 1'b0;
      rep_cnt   <= '0;
    end else if (inc_press) begin
      rep_armed <= 1'b1;
      rep_cnt   <= '0;
    end else if (rep_armed) begin
      rep_cnt <= (rep_cnt == REPEAT_LAST) ? '0 : rep_cnt + RW'(1);
    end
  end
`else
  logic unused_levels;

  assign unused_levels = &{1'b0, mode_level, inc_level};
  assign repeat_tick   = 1'b0;
`endif

  assign inc_evt = (inc_press | repeat_tick) & ~mode_press;

  always_comb begin
    state_d = state_q;
    case (state_q)
      MODE_RUN:     if (mode_press) state_d = MODE_SET_HR;
      MODE_SET_HR:  if (mode_press) state_d = MODE_SET_MIN;
      MODE_SET_MIN: if (mode_press) state_d = MODE_RUN;
      default:      state_d = MODE_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= MODE_RUN;
      hours_q   <= '0;
      minutes_q <= '0;
      load_q    <= 1'b0;
      run_en_q  <= 1'b1;
      blink_cnt <= '0;
      blink_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= (state_q == MODE_SET_MIN) && mode_press;
      // Requiring a full cycle in RUN delays run_en by one cycle past the load pulse.
      run_en_q <= (state_d == MODE_RUN) && (state_q == MODE_RUN);

      if (state_q == MODE_RUN && mode_press) begin
        hours_q   <= cur_hours;
        minutes_q <= cur_minutes;
      end else if (inc_evt) begin
        if (state_q == MODE_SET_HR)  hours_q   <= next_hours(hours_q);
        if (state_q == MODE_SET_MIN) minutes_q <= next_minutes(minutes_q);
      end

      if (state_d != state_q || state_q == MODE_RUN) begin
        blink_cnt <= '0;
        blink_q   <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_q   <= ~blink_q;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  always_comb begin
    blank_mask = '0;
    case (state_q)
      MODE_SET_HR:  blank_mask[5:4] = {2{blink_q}};
      MODE_SET_MIN: blank_mask[3:2] = {2{blink_q}};
      default:      blank_mask = '0;
    endcase
  end

  assign mode         = state_q;
  assign run_en       = run_en_q;
  assign load         = load_q;
  assign load_hours   = hours_q;
  assign load_minutes = minutes_q;
  assign load_seconds = '0;

endmodule
